// File: rtl/hps_ps2_dev_pkg.sv
// Shared definitions for the PS/2 device emulator.
//   state_e        : controller states
//   PS2_FRAME_BITS : device-to-host frame length (start, 8 data, parity, stop)
//   PS2_RX_BITS    : host-to-device bits clocked in after the RTS start bit
//   SYNC_LATENCY   : depth of the input synchronisers in clk_sys cycles
//   odd_parity()   : parity bit that makes the 9-bit group odd
package hps_ps2_dev_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_RX_ACK,
        ST_HOLD
    } state_e;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_RX_BITS    = 10;
    localparam int SYNC_LATENCY   = 2;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/hps_ps2_dev_fifo.sv
// Byte FIFO feeding the device-to-host transmitter.
//   clk_sys, reset : clock, synchronous active-high reset (empties the FIFO)
//   push_i, din_i  : write strobe and byte; ignored while full
//   pop_i          : discard the head byte; ignored while empty
//   dout_o         : head byte (valid while !empty_o)
//   empty_o/full_o : occupancy flags
module hps_ps2_dev_fifo #(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int DEPTH = 2 ** FIFO_BITS;

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [FIFO_BITS:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]         mem_q [DEPTH];
    logic               push_ok, pop_ok;

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk_sys) begin
        if (push_ok) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                     (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);

endmodule

// File: rtl/hps_ps2_dev.sv
// PS/2 device emulator for one channel (keyboard or mouse).
//   clk_sys, reset            : system clock, synchronous active-high reset
//   tx_wr, tx_din             : push a byte for transmission to the host
//   tx_full, tx_overflow      : FIFO full; sticky "pushed while full"
//   ps2_clk_out, ps2_data_out : open-drain drives (0 = pull low, 1 = release)
//   ps2_clk_in, ps2_data_in   : wired-AND line levels (asynchronous)
//   rx_byte, rx_strobe, rx_err: host command byte, good/bad frame pulses
//   busy                      : controller not idle
module hps_ps2_dev
    import hps_ps2_dev_pkg::*;
#(
    parameter int PS2DIV    = 1000,
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tx_wr,
    input  logic [7:0] tx_din,
    output logic       tx_full,
    output logic       tx_overflow,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_err,
    output logic       busy
);

    localparam int                CNT_W      = $clog2(PS2DIV + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(PS2DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_SETTLE = CNT_W'(SYNC_LATENCY);
    localparam logic [3:0]        TX_LAST    = 4'(PS2_FRAME_BITS - 1);
    localparam logic [3:0]        RX_LAST    = 4'(PS2_RX_BITS - 1);

    // ---------------------------------------------------------------- sync
    logic [1:0] clk_sync_q, data_sync_q;
    logic       clk_s, data_s;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // ---------------------------------------------------------------- regs
    state_e                  state_q, state_d;
    logic                    half_q, half_d;       // 1 = clock-low half
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic [PS2_RX_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic [PS2_RX_BITS-1:0]  rx_frame;
    logic [CNT_W-1:0]        div_cnt_q;
    logic                    tick;
    logic                    rx_ok, rx_bad, fifo_pop;
    logic                    fifo_empty, fifo_full;
    logic [7:0]              fifo_dout;
    logic [7:0]              rx_byte_q;
    logic                    rx_strobe_q, rx_err_q, overflow_q;
    logic [PS2_FRAME_BITS-1:0] tx_frame;

    hps_ps2_dev_fifo #(.FIFO_BITS(FIFO_BITS)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push_i  (tx_wr),
        .pop_i   (fifo_pop),
        .din_i   (tx_din),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Half-period divider; parked at zero in IDLE so every frame starts
    // with a full-length first half.
    always_ff @(posedge clk_sys) begin
        if (reset || state_q == ST_IDLE) div_cnt_q <= '0;
        else if (tick)                   div_cnt_q <= '0;
        else                             div_cnt_q <= div_cnt_q + 1'b1;
    end

    assign tick     = (div_cnt_q == CNT_MAX);
    assign rx_frame = {data_s, rx_shift_q[PS2_RX_BITS-1:1]};
    assign tx_frame = {1'b1, odd_parity(tx_byte_q), tx_byte_q, 1'b0};

    // ------------------------------------------------------ state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            half_q     <= 1'b0;
            bit_cnt_q  <= '0;
            tx_byte_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_byte_q  <= tx_byte_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ------------------------------------------------------ next state
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        bit_cnt_d  = bit_cnt_q;
        tx_byte_d  = tx_byte_q;
        rx_shift_d = rx_shift_q;
        fifo_pop   = 1'b0;
        rx_ok      = 1'b0;
        rx_bad     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                half_d    = 1'b0;
                bit_cnt_d = '0;
                if (!clk_s) begin
                    state_d = ST_IDLE;            // host inhibit
                end else if (!data_s) begin
                    state_d = ST_RX;              // request-to-send wins
                    half_d  = 1'b1;               // first edge is a fall
                end else if (!fifo_empty) begin
                    state_d   = ST_TX;
                    tx_byte_d = fifo_dout;
                end
            end

            ST_TX: begin
                // The synchronised clock still shows our own low half for
                // SYNC_LATENCY cycles after release, so ignore it until then.
                if (!half_q && !clk_s && bit_cnt_q < TX_LAST &&
                    div_cnt_q >= CNT_SETTLE) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (bit_cnt_q == TX_LAST) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_HOLD;
                        half_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        half_d    = 1'b0;
                    end
                end
            end

            ST_RX: begin
                if (tick) begin
                    if (half_q) begin
                        half_d = 1'b0;
                    end else begin
                        rx_shift_d = rx_frame;
                        half_d     = 1'b1;
                        if (bit_cnt_q == RX_LAST) begin
                            state_d   = ST_RX_ACK;
                            bit_cnt_d = '0;
                            if (rx_frame[9] &&
                                rx_frame[8] == odd_parity(rx_frame[7:0]))
                                rx_ok = 1'b1;
                            else
                                rx_bad = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end

            ST_RX_ACK: begin
                if (tick) begin
                    half_d = 1'b0;
                    if (!half_q) state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (tick) begin
                    if (!half_q) half_d  = 1'b1;
                    else         state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ outputs
    always_comb begin
        ps2_clk_out  = 1'b1;
        ps2_data_out = 1'b1;
        unique case (state_q)
            ST_TX: begin
                ps2_clk_out  = ~half_q;
                ps2_data_out = tx_frame[bit_cnt_q];
            end
            ST_RX:     ps2_clk_out = ~half_q;
            ST_RX_ACK: begin
                ps2_clk_out  = ~half_q;
                ps2_data_out = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rx_byte_q   <= '0;
            rx_strobe_q <= 1'b0;
            rx_err_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rx_strobe_q <= rx_ok;
            rx_err_q    <= rx_bad;
            if (rx_ok)              rx_byte_q  <= rx_frame[7:0];
            if (tx_wr && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_strobe   = rx_strobe_q;
    assign rx_err      = rx_err_q;
    assign tx_full     = fifo_full;
    assign tx_overflow = overflow_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hps_ps2_dev.sv
// Directed/randomised bench for hps_ps2_dev with PS2DIV=4, FIFO_BITS=3.
// The host side is modelled as open-drain lines ANDed with the device drives.
module tb_hps_ps2_dev;

    localparam int PS2DIV    = 4;
    localparam int FIFO_BITS = 3;
    localparam int DEPTH     = 2 ** FIFO_BITS;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       tx_wr   = 1'b0;
    logic [7:0] tx_din  = 8'h00;
    logic       host_clk  = 1'b1;
    logic       host_data = 1'b1;
    logic       tx_full, tx_overflow, ps2_clk_out, ps2_data_out;
    logic       line_clk, line_data;
    logic [7:0] rx_byte;
    logic       rx_strobe, rx_err, busy;

    assign line_clk  = ps2_clk_out & host_clk;
    assign line_data = ps2_data_out & host_data;

    hps_ps2_dev #(.PS2DIV(PS2DIV), .FIFO_BITS(FIFO_BITS)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .tx_wr        (tx_wr),
        .tx_din       (tx_din),
        .tx_full      (tx_full),
        .tx_overflow  (tx_overflow),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .ps2_clk_in   (line_clk),
        .ps2_data_in  (line_data),
        .rx_byte      (rx_byte),
        .rx_strobe    (rx_strobe),
        .rx_err       (rx_err),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: PS/2 odd parity and the 11-bit wire frame, LSB first.
    function automatic logic par_bit(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0);
    endfunction

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = par_bit(b);
        f[10] = 1'b1;
        return f;
    endfunction

    // Host receiver: sample data at each device clock fall.
    task automatic recv_frame(output logic [10:0] f, output int bad_low, output bit timed_out);
        int   n = 0;
        int   budget = 1000;
        int   lowc = 0;
        logic prev;
        f = '0;
        bad_low = 0;
        prev = ps2_clk_out;
        while (n < 11 && budget > 0) begin
            @(negedge clk_sys);
            budget--;
            if (prev && !ps2_clk_out) begin
                f[n] = ps2_data_out;
                n++;
                lowc = 0;
            end
            if (!ps2_clk_out) lowc++;
            else if (!prev && n > 0 && lowc != PS2DIV) bad_low++;
            prev = ps2_clk_out;
        end
        timed_out = (n < 11);
    endtask

    task automatic wait_falls(input int cnt, output bit timed_out);
        int   n = 0;
        int   budget = 1000;
        logic prev = ps2_clk_out;
        while (n < cnt && budget > 0) begin
            @(negedge clk_sys);
            budget--;
            if (prev && !ps2_clk_out) n++;
            prev = ps2_clk_out;
        end
        timed_out = (n < cnt);
    endtask

    task automatic wait_rise(output bit timed_out);
        int   budget = 100;
        logic prev = ps2_clk_out;
        timed_out = 1'b1;
        while (budget > 0) begin
            @(negedge clk_sys);
            budget--;
            if (!prev && ps2_clk_out) begin
                timed_out = 1'b0;
                break;
            end
            prev = ps2_clk_out;
        end
    endtask

    task automatic quiet(input int cycles, output int falls);
        logic prev = ps2_clk_out;
        falls = 0;
        repeat (cycles) begin
            @(negedge clk_sys);
            if (prev && !ps2_clk_out) falls++;
            prev = ps2_clk_out;
        end
    endtask

    // Host-to-device transfer: RTS, then present one bit per device clock fall.
    task automatic host_send(input logic [9:0] bits, output int strobes, output int errs,
                             output int ack_low, output bit timed_out);
        int   n = 0;
        int   budget = 600;
        logic prev;
        strobes = 0;
        errs    = 0;
        ack_low = 0;
        host_clk = 1'b0;
        repeat (6) @(negedge clk_sys);
        host_data = 1'b0;
        repeat (2) @(negedge clk_sys);
        host_clk = 1'b1;
        prev = ps2_clk_out;
        timed_out = 1'b1;
        while (budget > 0) begin
            @(negedge clk_sys);
            budget--;
            if (prev && !ps2_clk_out && n < 10) begin
                host_data = bits[n];
                n++;
            end
            strobes += int'(rx_strobe);
            errs    += int'(rx_err);
            if (!ps2_data_out) ack_low++;
            prev = ps2_clk_out;
            if (n == 10 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        host_data = 1'b1;
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  exp_q[$];
        logic [7:0]  b, pushed;
        int          bad_low, falls, strobes, errs, ack_low;
        bit          to;

        // ---- reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_clk_out", ps2_clk_out, 1'b1);
        chk("rst_data_out", ps2_data_out, 1'b1);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_overflow", tx_overflow, 1'b0);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_rx_strobe", rx_strobe, 1'b0);
        chk("rst_rx_err", rx_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);

        // ---- single byte 8'h1C
        tx_din = 8'h1C;
        tx_wr  = 1'b1;
        @(negedge clk_sys);
        tx_wr = 1'b0;
        recv_frame(f, bad_low, to);
        chk("tx1c_timeout", to, 1'b0);
        chk("tx1c_frame", f, model_frame(8'h1C));
        chk("tx1c_frame_literal", f, 11'b100_0011_1000);
        chk("tx1c_low_len", bad_low, 0);
        quiet(60, falls);
        chk("tx1c_no_more", falls, 0);
        chk("tx1c_idle", busy, 1'b0);

        // ---- fill while inhibited, overflow, ordered drain
        host_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < DEPTH + 1; i++) begin
            pushed = 8'($urandom);
            tx_din = pushed;
            tx_wr  = 1'b1;
            if (i < DEPTH) exp_q.push_back(pushed);
            @(negedge clk_sys);
            if (i == DEPTH - 2) chk("ovf_not_full_7", tx_full, 1'b0);
            if (i == DEPTH - 1) begin
                chk("ovf_full_8", tx_full, 1'b1);
                chk("ovf_flag_clear_8", tx_overflow, 1'b0);
            end
        end
        tx_wr = 1'b0;
        chk("ovf_flag_set", tx_overflow, 1'b1);
        chk("ovf_inhibit_idle", busy, 1'b0);
        host_clk = 1'b1;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            recv_frame(f, bad_low, to);
            chk("ovf_timeout", to, 1'b0);
            chk("ovf_frame", f, model_frame(b));
        end
        quiet(60, falls);
        chk("ovf_ninth_dropped", falls, 0);
        chk("ovf_drained", tx_full, 1'b0);
        chk("ovf_sticky", tx_overflow, 1'b1);

        // ---- host inhibit during bit 5 of 8'hAA
        tx_din = 8'hAA;
        tx_wr  = 1'b1;
        @(negedge clk_sys);
        tx_wr = 1'b0;
        wait_falls(5, to);
        chk("abort_falls_timeout", to, 1'b0);
        wait_rise(to);
        chk("abort_rise_timeout", to, 1'b0);
        host_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("abort_clk_rel", ps2_clk_out, 1'b1);
        chk("abort_data_rel", ps2_data_out, 1'b1);
        chk("abort_busy", busy, 1'b0);
        repeat (20) @(negedge clk_sys);
        chk("abort_held_idle", busy, 1'b0);
        host_clk = 1'b1;
        recv_frame(f, bad_low, to);
        chk("abort_resend_timeout", to, 1'b0);
        chk("abort_resend_frame", f, model_frame(8'hAA));
        quiet(60, falls);
        chk("abort_sent_once", falls, 0);

        // ---- host command 8'hED with correct parity
        host_send({1'b1, par_bit(8'hED), 8'hED}, strobes, errs, ack_low, to);
        chk("rxed_timeout", to, 1'b0);
        chk("rxed_strobes", strobes, 1);
        chk("rxed_errs", errs, 0);
        chk("rxed_byte", rx_byte, 8'hED);
        chk("rxed_ack_len", ack_low, 2 * PS2DIV);

        // ---- host command 8'hF4 with inverted parity
        host_send({1'b1, ~par_bit(8'hF4), 8'hF4}, strobes, errs, ack_low, to);
        chk("rxf4_timeout", to, 1'b0);
        chk("rxf4_strobes", strobes, 0);
        chk("rxf4_errs", errs, 1);
        chk("rxf4_byte_kept", rx_byte, 8'hED);
        chk("rxf4_ack_len", ack_low, 2 * PS2DIV);

        // ---- reset during bit 4 of a full FIFO's first frame
        for (int i = 0; i < DEPTH; i++) begin
            tx_din = 8'($urandom);
            tx_wr  = 1'b1;
            @(negedge clk_sys);
        end
        tx_wr = 1'b0;
        chk("rstmid_full", tx_full, 1'b1);
        wait_falls(4, to);
        chk("rstmid_falls_timeout", to, 1'b0);
        wait_rise(to);
        chk("rstmid_rise_timeout", to, 1'b0);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rstmid_clk_out", ps2_clk_out, 1'b1);
        chk("rstmid_data_out", ps2_data_out, 1'b1);
        chk("rstmid_tx_full", tx_full, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_overflow", tx_overflow, 1'b0);
        reset = 1'b0;
        quiet(150, falls);
        chk("rstmid_no_frame", falls, 0);
        chk("rstmid_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
